// File: rtl/aes_key_pkg.sv
// Shared constants, FSM state type and round-constant lookup for the
// AES-128 key scheduler.
package aes_key_pkg;

  localparam int ROUNDS = 10;
  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    RUN
  } state_t;

  // Rcon byte for the expansion step that produces round key idx+1.
  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_scheduler_expander.sv
// Single-step AES-128 key expander. Forward mode turns round key r into r+1;
// inverse mode turns round key r+1 back into r. The SubWord S-box is outside:
// g_in is the rotated word to substitute, g_out the substituted result.
module key_expander
  import aes_key_pkg::*;
(
  input  logic              enc_dec,
  input  logic [IDX_W-1:0]  round,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              add_w_out,
  output logic [WORD_W-1:0] g_in,
  input  logic [WORD_W-1:0] g_out,
  output logic [KEY_W-1:0]  key_out
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] last_w;
  logic [WORD_W-1:0] g;
  logic [IDX_W-1:0]  rc_idx;
  logic [KEY_W-1:0]  step;

  assign {w0, w1, w2, w3} = key_in;

  // In inverse mode the last word of the earlier key is w3^w2 of the later
  // one, and the step counter runs from the top round down.
  always_comb begin
    last_w = enc_dec ? w3 : (w3 ^ w2);
    rc_idx = enc_dec ? round : (IDX_W'(ROUNDS - 1) - round);
    g_in   = {last_w[23:0], last_w[31:24]};
    g      = g_out ^ {rcon(rc_idx), 24'h000000};
  end

  // Word recurrence, forward or inverted; add_w_out folds the input back in.
  always_comb begin
    logic [WORD_W-1:0] n0, n1, n2;
    if (enc_dec) begin
      n0   = w0 ^ g;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      step = {n0, n1, n2, w3 ^ n2};
    end else begin
      n0   = '0;
      n1   = '0;
      n2   = '0;
      step = {w0 ^ g, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end
    key_out = add_w_out ? (step ^ key_in) : step;
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 round-key scheduler: pre-computes the round-10 key once per cipher
// key, then serves round keys one per request, forward or reverse.
//
// state  | meaning
// IDLE   | no valid key
// EXPAND | forward pre-computation of the round-10 key
// READY  | keys valid, no sequence active
// RUN    | serving round keys on next
module aes_key_scheduler #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         start,
  input  logic         enc_dec,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic         sbox_req,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);
  import aes_key_pkg::*;

  state_t            state, state_nxt;
  logic [KEY_W-1:0]  key_reg, dec_key, work;
  logic [IDX_W-1:0]  cnt;
  logic              mode;
  logic              load, go, step, last;
  logic              exp_enc;
  logic [KEY_W-1:0]  exp_key, exp_out;

  assign last    = (cnt == IDX_W'(ROUNDS - 1));
  assign exp_enc = (state == EXPAND) | mode;
  assign exp_key = (state == EXPAND) ? work : round_key;

  key_expander u_expander (
    .enc_dec   (exp_enc),
    .round     (cnt),
    .key_in    (exp_key),
    .add_w_out (1'b0),
    .g_in      (sbox_in),
    .g_out     (sbox_out),
    .key_out   (exp_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode; a key offer in READY beats start.
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    sbox_req  = 1'b0;
    load      = 1'b0;
    go        = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy     = 1'b1;
        sbox_req = 1'b1;
        if (last) state_nxt = READY;
      end
      READY: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end else if (start) begin
          go        = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (next) begin
          step     = 1'b1;
          sbox_req = 1'b1;
          if (last) state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key registers, step counter and served round key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg   <= '0;
      dec_key   <= '0;
      work      <= '0;
      cnt       <= '0;
      mode      <= 1'b1;
      round_key <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= step & last;
      if (load) begin
        key_reg <= key_in;
        work    <= key_in;
        cnt     <= '0;
      end else if (state == EXPAND) begin
        work <= exp_out;
        cnt  <= cnt + IDX_W'(1);
        if (last) dec_key <= exp_out;
      end else if (go) begin
        round_key <= enc_dec ? key_reg : dec_key;
        round_idx <= enc_dec ? '0 : IDX_W'(ROUNDS);
        cnt       <= '0;
        mode      <= enc_dec;
      end else if (step) begin
        round_key <= exp_out;
        round_idx <= mode ? (round_idx + IDX_W'(1)) : (round_idx - IDX_W'(1));
        cnt       <= cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: external S-box model, a
// behavioural key-schedule reference, per-cycle output compare and FIPS-197
// literal checkpoints.
module tb_aes_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         start;
  logic         enc_dec;
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic         sbox_req;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK9 = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_scheduler #(.ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .start     (start),
    .enc_dec   (enc_dec),
    .next      (next),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .sbox_req  (sbox_req),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- GF(2^8) S-box ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb sbox_out = subword(sbox_in);

  // ---------------- reference key schedule ----------------
  logic [127:0] rk [0:10];

  function automatic void model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_left;
  bit           m_have, m_run, m_enc, m_done;
  int           m_pos;
  logic [127:0] m_rk;
  logic [3:0]   m_idx;

  // Advance the reference one clock (or clear it on reset).
  always @(posedge clk or posedge rst) begin : model
    bit rdy;
    if (rst) begin
      m_left = 0; m_have = 0; m_run = 0; m_enc = 1; m_done = 0;
      m_pos = 0; m_rk = '0; m_idx = '0;
    end else begin
      rdy    = !m_run && m_left == 0;
      m_done = 0;
      if (key_valid && rdy) begin
        model_expand(key_in);
        m_left = 10;
        m_have = 1;
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_run) begin
        if (next) begin
          m_pos++;
          m_idx = m_enc ? 4'(m_pos) : 4'(10 - m_pos);
          m_rk  = rk[m_idx];
          if (m_pos == 10) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end else if (m_have && start) begin
        m_run = 1; m_enc = enc_dec; m_pos = 0;
        m_idx = enc_dec ? 4'd0 : 4'd10;
        m_rk  = enc_dec ? rk[0] : rk[10];
      end
    end
  end

  // Compare every output against the reference away from the clock edge.
  always @(negedge clk) begin : compare
    bit          exp_sreq;
    int          k;
    logic [31:0] w;
    if (chk_en) begin
      exp_sreq = (m_left > 0) || (m_run && next);
      check("key_ready", 128'(key_ready), 128'(!m_run && m_left == 0));
      check("busy", 128'(busy), 128'(m_left > 0));
      check("done", 128'(done), 128'(m_done));
      check("sbox_req", 128'(sbox_req), 128'(exp_sreq));
      check("round_key", round_key, m_rk);
      check("round_idx", 128'(round_idx), 128'(m_idx));
      if (exp_sreq) begin
        k = (m_left > 0) ? (10 - m_left) : (m_enc ? int'(m_idx) : int'(m_idx) - 1);
        w = rk[k][31:0];
        check("sbox_in", 128'(sbox_in), 128'({w[23:0], w[31:24]}));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    check("wait_ready", 128'(key_ready), 128'(1));
  endtask

  task automatic load_key(input logic [127:0] k, input bit stray);
    int n = 0;
    wait_ready();
    key_valid = 1; key_in = k;
    tick();
    key_valid = 0;
    while (busy && n < 20) begin
      if (stray) begin
        start   = 1'($urandom_range(0, 1));
        enc_dec = 1'($urandom_range(0, 1));
        next    = 1'($urandom_range(0, 1));
      end
      n++;
      tick();
    end
    start = 0; next = 0;
    check("busy_cycles", 128'(n), 128'(10));
  endtask

  task automatic run_seq(input bit enc, input bit gapped);
    start = 1; enc_dec = enc;
    tick();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      if (gapped) begin
        repeat ($urandom_range(0, 3)) begin
          start     = 1'($urandom_range(0, 1));
          key_valid = 1'($urandom_range(0, 1));
          key_in    = {$urandom, $urandom, $urandom, $urandom};
          tick();
        end
        start = 0; key_valid = 0;
      end
      next = 1;
      tick();
      next = 0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; key_valid = 0; key_in = '0; start = 0; enc_dec = 1; next = 0;

    model_expand(FIPS_KEY);
    check("pin_rk1", rk[1], FIPS_RK1);
    check("pin_rk9", rk[9], FIPS_RK9);
    check("pin_rk10", rk[10], FIPS_RK10);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_round_key", round_key, 128'h0);
    rst = 0;
    tick();

    start = 1; next = 1;
    tick();
    start = 0; next = 0;
    check("start_no_key_idx", 128'(round_idx), 128'(0));

    // FIPS-197 encrypt, back-to-back next, stray inputs during EXPAND
    load_key(FIPS_KEY, 1);
    start = 1; enc_dec = 1;
    tick();
    start = 0;
    check("enc_start_key", round_key, FIPS_KEY);
    next = 1;
    tick();
    check("enc_idx1", 128'(round_idx), 128'(1));
    check("enc_rk1", round_key, FIPS_RK1);
    repeat (9) tick();
    next = 0;
    check("enc_done", 128'(done), 128'(1));
    check("enc_rk10", round_key, FIPS_RK10);
    tick();
    check("enc_done_pulse", 128'(done), 128'(0));
    check("enc_retain", round_key, FIPS_RK10);

    // FIPS-197 decrypt with gaps
    start = 1; enc_dec = 0;
    tick();
    start = 0;
    check("dec_start_key", round_key, FIPS_RK10);
    check("dec_start_idx", 128'(round_idx), 128'(10));
    next = 1;
    tick();
    next = 0;
    check("dec_rk9", round_key, FIPS_RK9);
    check("dec_idx9", 128'(round_idx), 128'(9));
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      next = 1;
      tick();
      next = 0;
    end
    check("dec_rk0", round_key, FIPS_KEY);
    check("dec_idx0", 128'(round_idx), 128'(0));

    // key reuse: second decrypt without reload
    run_seq(0, 1);
    check("reuse_rk0", round_key, FIPS_KEY);

    // key_valid beats start in READY
    key_valid = 1; key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1; enc_dec = 1;
    tick();
    key_valid = 0; start = 0;
    check("kv_start_busy", 128'(busy), 128'(1));
    check("kv_start_no_run", round_key, FIPS_KEY);

    // randomized keys and sequences
    for (int it = 0; it < 6; it++) begin
      load_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        next = 1;
        tick();
        next = 0;
      end
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_seq(1'($urandom_range(0, 1)), 1);
    end

    // mid-run reset
    load_key(FIPS_KEY, 0);
    start = 1; enc_dec = 1;
    tick();
    start = 0;
    next = 1;
    repeat (5) tick();
    next = 0;
    check("pre_rst_idx", 128'(round_idx), 128'(5));
    rst = 1;
    #1;
    check("mid_rst_round_key", round_key, 128'h0);
    check("mid_rst_idx", 128'(round_idx), 128'(0));
    check("mid_rst_key_ready", 128'(key_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    tick();
    rst = 0;
    start = 1; enc_dec = 0;
    tick();
    start = 0;
    tick();
    check("post_rst_start_ignored", 128'(round_idx), 128'(0));
    check("post_rst_key_zero", round_key, 128'h0);
    load_key(FIPS_KEY, 0);
    run_seq(0, 0);
    check("post_rst_dec_rk0", round_key, FIPS_KEY);

    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential round-key scheduler for the AES-128 core. It accepts a cipher key, pre-computes the round-10 key, and then serves round keys one per request. Keys are served in forward order for encryption and reverse order for decryption. It drives the single-step `key_expander` and shares the datapath's 32-bit SubWord S-box through a request-qualified port.

## Interface
- `ROUNDS`, 10: number of AES rounds; fixed for AES-128.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `key_valid`  in  1  cipher key offered.
- `key_in`  in  128  cipher key, word 0 in bits [127:96].
- `key_ready`  out  1  scheduler accepts a key this cycle.
- `start`  in  1  begin a key sequence.
- `enc_dec`  in  1  sampled with `start`: 1 = encrypt (forward), 0 = decrypt (reverse).
- `next`  in  1  advance one round key.
- `round_key`  out  128  current round key, registered.
- `round_idx`  out  4  index of `round_key`, 0..10.
- `busy`  out  1  key pre-computation in progress.
- `done`  out  1  one-cycle pulse: final key of the sequence is now on `round_key`.
- `sbox_req`  out  1  scheduler uses the S-box this cycle.
- `sbox_in`  out  32  SubWord input (expander `g_in`).
- `sbox_out`  in  32  SubWord result, combinational from `sbox_in`.

## Operation
- **States:**
  - IDLE: no valid key.
  - EXPAND: forward pre-computation.
  - READY: keys valid, no sequence active.
  - RUN: serving keys.
- **Key load:**
  - `key_ready` = 1 in IDLE and READY, 0 otherwise.
  - `key_valid & key_ready` stores `key_in` in `key_reg` and `work`, clears step counter `cnt`, and enters EXPAND.
- **EXPAND:**
  - Each cycle the expander runs with `enc_dec` = 1, `round` = `cnt`, and `key_in` = `work`.
  - `work` <= `key_out`; `cnt` increments; `sbox_req` = 1.
  - When `cnt` = 9, `key_out` is written to `dec_key` and the state goes to READY. EXPAND lasts exactly 10 cycles.
- **Start (READY only):**
  - encrypt: `round_key` <= `key_reg`, `round_idx` <= 0.
  - decrypt: `round_key` <= `dec_key`, `round_idx` <= 10.
  - Also clears `cnt`, latches `enc_dec`, and enters RUN.
  - If `key_valid` and `start` arrive together in READY, `key_valid` wins and `start` is dropped.
- **RUN:**
  - On `next`, the expander runs with the latched `enc_dec`, `round` = `cnt`, and `key_in` = `round_key`.
  - `round_key` <= `key_out`; `round_idx` moves +1 (encrypt) or -1 (decrypt); `cnt`++; `sbox_req` = `next`.
  - The 10th `next` (`cnt` = 9) also asserts `done` on the following cycle and returns the state to READY.
- **Expander control:** `add_w_out` is tied to 0. In IDLE and READY, and in RUN without `next`, `sbox_req` = 0.
- **Ignored inputs:**
  - `next` outside RUN and `start` outside READY are ignored.
  - `key_valid` is ignored while `key_ready` = 0.
- **Key retention:** `round_key` and `round_idx` hold their values between requests and after the sequence ends, until the next `start` or reset. Repeated `start` reuses the stored `dec_key` with no re-expansion.
- **Reset:**
  - Asserting `rst` at any time, including mid-EXPAND or mid-RUN, immediately forces IDLE.
  - Reset values: `round_key`, `key_reg`, `dec_key`, `work` = 0; `round_idx`, `cnt` = 0; `busy`, `done`, `sbox_req` = 0; `key_ready` = 1; latched `enc_dec` = 1.
  - A new key must be loaded after reset.

## Timing
- **Key acceptance:** at the rising edge where `key_valid & key_ready` is high. `busy` goes high the next cycle.
- **Pre-computation:** `busy` stays high for 10 cycles. `key_ready` returns high on the 11th cycle after acceptance.
- **Start:** `round_key` is valid the cycle after `start`.
- **Next:** each `next` updates `round_key` one cycle later. Back-to-back `next` is allowed every cycle.
- **Throughput:** a full sequence takes 11 cycles (start + 10 next).
- **Combinational path:** `sbox_in` -> `sbox_out` -> expander -> register must close in one cycle. No pipelining.

## Structure
- **Package `aes_key_pkg`:**
  - `ROUNDS` = 10, `KEY_W` = 128, `WORD_W` = 32.
  - FSM state enum: IDLE, EXPAND, READY, RUN.
  - Round-index width = 4.
- **Sub-modules:** a single instance of the existing `key_expander`. The FSM, counters, and key registers live in `aes_key_scheduler`. The S-box stays external.

## Test plan
- **Encrypt sequence:**
  - Stimulus: load key 2b7e151628aed2a6abf7158809cf4f3c, wait `key_ready`, then `start` with `enc_dec` = 1, then `next`.
  - Response: `round_idx` = 1, `round_key` = a0fafe1788542cb123a339392a6c7605.
  - After 10 `next`: `round_key` = d014f9a8c9ee2589e13f0cc8b6630ca6, `done` pulses once.
- **Decrypt sequence:**
  - Stimulus: same key, `start` with `enc_dec` = 0.
  - Response: `round_key` = d014f9a8…, `round_idx` = 10; after one `next`, ac7766f319fadc2128d12941575c006e, `round_idx` = 9.
  - After 10 `next`: `round_key` = 2b7e1516…, `round_idx` = 0.
- **Pre-computation timing:** `busy` is high exactly 10 cycles, `sbox_req` = 1 throughout, and `key_ready` = 0 until cycle 11. `start` and `next` during EXPAND have no effect.
- **Simultaneous events:**
  - `key_valid` + `start` together in READY -> new key is loaded, no RUN.
  - Gapped `next` in RUN (random idle cycles) -> same key sequence as back-to-back.
- **Mid-operation reset:** `rst` after 5 `next` in RUN -> all outputs at reset values immediately; a following `start` is ignored until a key is reloaded.
- **Key reuse:** two decrypt sequences in a row without reloading -> identical key streams.
